fround_pipe: RTL and testbench
==============================

Name: fround_pipe

Overview:
- Parametrised, elastic two-stage float-to-integral rounding unit for the VLIW FPU lane.
- Successor to the fixed single-precision floor unit: per-operation rounding mode (RNE / trunc / floor / ceil), generic exponent and mantissa widths, NaN/Inf handling, an inexact flag, a writeback tag, and valid/ready backpressure.
- Sits between issue and the FPU writeback arbiter.

Parameters:
EW, 8, exponent width; bias B = 2^(EW-1)-1
MW, 23, stored mantissa width; FW = 1+EW+MW is the total float width
TAGW, 6, width of the opaque tag (destination register/slot), carried unchanged

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  operand valid
in_ready  out  1  unit can accept an operand this cycle
in_x  in  FW  operand {sign, exp, man}
in_mode  in  2  0=RNE, 1=RZ (trunc), 2=RM (floor), 3=RP (ceil)
in_tag  in  TAGW  writeback tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result this cycle
out_y  out  FW  rounded integral value, same float format
out_tag  out  TAGW  tag of the result
out_inexact  out  1  result differs from the input (non-NaN inputs only)

Behaviour:
Interface:
- One clock `clk`; reset `rstn` is synchronous and active-low.
- Reset (rstn=0 at a clk edge) clears both stage valids, so out_valid=0.
- Reset also clears out_y, out_tag and out_inexact to 0. Any in-flight operations are discarded, with no partial output.

Handshake (elastic, no bubbles):
- Stage-2 advance: a2 = !v2 | out_ready.
- Stage-1 advance: a1 = !v1 | a2.
- in_ready = a1. It is combinational from out_ready; there is no path from in_valid to in_ready.
- A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_y, out_tag and out_inexact hold stable.
- Latency is exactly 2 cycles with out_ready=1. Throughput is 1 per cycle.
- Results leave in issue order.

Stage 1:
- Classify the operand: e = exp field, and k = B+MW-e when e < B+MW.
- Integral already (e >= B+MW, finite): pass through unchanged, inexact=0.
- Inf: pass through unchanged, inexact=0.
- NaN: output is quietened (man MSB set), inexact=0.
- e==0 (zero or subnormal): flushed to a signed zero, inexact=0.
- B <= e < B+MW:
  - frac = low k bits of man; truncated mantissa mt = man with the low k bits cleared.
  - guard = bit k-1 of man; sticky = OR of bits below k-1; lsb = bit k of the significand, taken as 1 when k==MW (the hidden bit).
  - inc: RNE = guard & (sticky | lsb); RZ = 0; RM = sign & (frac!=0); RP = !sign & (frac!=0).
- 0 < e < B (|x| < 1):
  - Result magnitude is 1.0 if RNE & e==B-1 & man!=0; else 1.0 if RM & sign; else 1.0 if RP & !sign; otherwise 0.
  - Sign is always preserved, so -0.3 under ceil gives -0.0.
  - inexact=1.
- Register stage 1: sign, e, mt, inc, k, class, inexact, tag.

Stage 2:
- If inc: sum = {1, mt} + (1 << k), computed MW+2 bits wide.
- If the carry leaves the hidden bit, exp = e+1 and man = 0. Otherwise man = sum[MW-1:0].
- The exponent cannot overflow, because inputs with e >= B+MW never increment.
- inexact = (frac != 0) for finite normal inputs.
- Stage 2 is registered to the out_* ports.

Boundary cases:
- k==MW (1 <= |x| < 2): rounding uses the hidden bit as lsb. Example: 1.5 RNE -> 2.0.
- ±0 in any mode returns ±0 unchanged.
- Simultaneous input accept and output drain in the same cycle is legal and required.
- in_mode is sampled only at accept.

Decomposition:
- Shared package fpu_pkg:
  - rounding-mode localparams RM_RNE=0, RM_RZ=1, RM_DN=2, RM_UP=3
  - a class encoding (ZERO, NORM_FRAC, INTEGRAL, INF, NAN)
  - a bias(EW) constant function
- One sub-module: fround_decode, the combinational stage-1 classify/guard/sticky/inc logic, parametrised by EW and MW.
- The pipeline registers and handshake live in fround_pipe.

Test Plan:
1. Mode sweep, default widths, out_ready=1:
   - 0x40200000 (2.5) RNE -> 0x40000000, RM -> 0x40000000, RP -> 0x40400000, RZ -> 0x40000000; inexact=1.
   - Each result appears exactly 2 cycles after accept.
2. Carry into exponent:
   - 0x3FC00000 (1.5) RP -> 0x40000000.
   - 0xBF7FFFFF (-0.99999994) RM -> 0xBF800000.
   - 0xC0200000 (-2.5) RM -> 0xC0400000.
3. Specials:
   - 0x7F800001 -> 0x7FC00001.
   - 0xFF800000 -> 0xFF800000.
   - 0xBE99999A (-0.3) RP -> 0x80000000.
   - 0x00000001 -> 0x00000000.
   - 0x4B000001 unchanged with inexact=0.
4. Backpressure:
   - Issue 4 back-to-back ops with out_ready low for cycles 2-5.
   - Required: in_ready drops once both stages are full; outputs hold stable; all 4 drain in order with the correct tags; no loss or duplication.
5. Reset mid-operation:
   - Assert rstn=0 for one cycle with both stages valid.
   - Next cycle: out_valid=0 and out_y=0. No stale result appears afterwards; a new op completes in 2 cycles.
6. Parameter instance EW=11, MW=52:
   - 0x4004000000000000 (2.5) RNE -> 0x4000000000000000.
   - 0xC004000000000000 (-2.5) RM -> 0xC008000000000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: rounding-mode codes, operand class encoding and exponent bias helper shared by FPU lane units
package fpu_pkg;
  localparam logic [1:0] RM_RNE = 2'd0, RM_RZ = 2'd1, RM_DN = 2'd2, RM_UP = 2'd3;
  typedef enum logic [2:0] {CL_ZERO, CL_NORM_FRAC, CL_INTEGRAL, CL_INF, CL_NAN} fclass_t;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
endpackage

// File: rtl/fround_decode.sv
// fround_decode: stage-1 classify plus guard/sticky/increment decision for float-to-integral rounding
module fround_decode
  import fpu_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0]             x,
  input  logic [1:0]                 mode,
  output logic                       sign,
  output logic [EW-1:0]              e,
  output logic [MW-1:0]              mt,
  output logic                       inc,
  output logic [$clog2(MW+1)-1:0]    k,
  output fclass_t                    cls,
  output logic                       inexact
);
  localparam int KW = $clog2(MW + 1);
  localparam int B = bias(EW);
  localparam logic [EW-1:0] EB = EW'(B);
  localparam logic [EW-1:0] EB1 = EW'(B - 1);
  localparam logic [EW:0] EI = (EW+1)'(B + MW);
  localparam logic [KW-1:0] KT = KW'(B + MW);
  logic [EW-1:0] ex;
  logic [MW-1:0] man, fm, gm;
  logic is_zero, is_nan, is_inf, is_int, is_small, frac_nz, guard, sticky, lsb, one, inc_f;
  assign sign = x[EW+MW];
  assign ex = x[EW+MW-1:MW];
  assign man = x[MW-1:0];
  // k wraps modulo 2^KW; only meaningful (1..MW) for the fractional class
  assign k = KT - KW'(ex);
  assign fm = ~({MW{1'b1}} << k);
  assign gm = fm & ~(fm >> 1);
  assign frac_nz = |(man & fm);
  assign guard = |(man & gm);
  assign sticky = |(man & (fm >> 1));
  assign lsb = (k == KW'(MW)) | (|(man & (gm << 1)));
  assign is_zero = ~|ex;
  assign is_nan = (&ex) & (|man);
  assign is_inf = (&ex) & ~|man;
  assign is_int = {1'b0, ex} >= EI;
  assign is_small = !is_zero && ex < EB;
  assign one = mode == RM_RNE ? (ex == EB1 && |man) :
               mode == RM_DN  ? sign :
               mode == RM_UP  ? !sign : 1'b0;
  assign inc_f = mode == RM_RNE ? guard & (sticky | lsb) :
                 mode == RM_DN  ? sign & frac_nz :
                 mode == RM_UP  ? !sign & frac_nz : 1'b0;
  assign cls = is_nan ? CL_NAN : is_inf ? CL_INF : is_zero ? CL_ZERO : is_int ? CL_INTEGRAL : CL_NORM_FRAC;
  assign e = is_zero ? '0 : is_small ? (one ? EB : '0) : ex;
  assign mt = is_nan ? man | (MW'(1) << (MW - 1)) :
              (is_zero | is_small) ? '0 :
              (is_inf | is_int) ? man : man & ~fm;
  assign inc = cls == CL_NORM_FRAC && !is_small && inc_f;
  assign inexact = cls == CL_NORM_FRAC && (is_small || frac_nz);
endmodule

// File: rtl/fround_pipe.sv
// fround_pipe: elastic two-stage float-to-integral rounding unit with per-op mode, tag and inexact flag
module fround_pipe
  import fpu_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TAGW = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    in_x,
  input  logic [1:0]        in_mode,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    out_y,
  output logic [TAGW-1:0]   out_tag,
  output logic              out_inexact
);
  localparam int KW = $clog2(MW + 1);
  logic d_sign, d_inc, d_inx;
  logic [EW-1:0] d_e;
  logic [MW-1:0] d_mt;
  logic [KW-1:0] d_k;
  fclass_t d_cls;
  logic v1, v2, a1, a2;
  logic s1_sign, s1_inc, s1_inx;
  logic [EW-1:0] s1_e;
  logic [MW-1:0] s1_mt;
  logic [KW-1:0] s1_k;
  fclass_t s1_cls;
  logic [TAGW-1:0] s1_tag;
  logic [MW:0] sum;
  logic bump;
  logic [EW+MW:0] y2;
  fround_decode #(.EW(EW), .MW(MW)) u_dec (
    .x(in_x), .mode(in_mode), .sign(d_sign), .e(d_e), .mt(d_mt),
    .inc(d_inc), .k(d_k), .cls(d_cls), .inexact(d_inx)
  );
  assign a2 = !v2 | out_ready;
  assign a1 = !v1 | a2;
  assign in_ready = a1;
  assign out_valid = v2;
  // carry out of the MW-bit truncated mantissa is exactly the carry past the hidden bit
  assign sum = {1'b0, s1_mt} + ((MW+1)'(1) << s1_k);
  assign bump = s1_inc && s1_cls == CL_NORM_FRAC;
  assign y2 = bump ? {s1_sign, s1_e + EW'(sum[MW]), sum[MW-1:0]} : {s1_sign, s1_e, s1_mt};
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_y <= '0;
      out_tag <= '0;
      out_inexact <= 1'b0;
    end else begin
      if (a1) begin
        v1 <= in_valid;
        s1_sign <= d_sign;
        s1_e <= d_e;
        s1_mt <= d_mt;
        s1_inc <= d_inc;
        s1_k <= d_k;
        s1_cls <= d_cls;
        s1_inx <= d_inx;
        s1_tag <= in_tag;
      end
      if (a2) v2 <= v1;
      if (a2 && v1) begin
        out_y <= y2;
        out_tag <= s1_tag;
        out_inexact <= s1_inx;
      end
    end
  end
endmodule

// File: tb/tb_fround_pipe.sv
// tb_fround_pipe: directed and randomized checks of fround_pipe against an integer-arithmetic rounding model
module tb_fround_pipe;
  logic clk = 1'b0, rstn;
  logic in_valid, in_ready, out_valid, out_ready, out_inexact;
  logic [31:0] in_x, out_y;
  logic [1:0] in_mode;
  logic [5:0] in_tag, out_tag;
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_inexact;
  logic [63:0] d_in_x, d_out_y;
  logic [1:0] d_in_mode;
  logic [5:0] d_in_tag, d_out_tag;
  int compared = 0, mismatched = 0, now = 0;
  typedef struct {logic [31:0] y; logic inx; logic [5:0] tag; int cyc;} exp_t;
  exp_t q[$];
  logic stalled = 1'b0, h_inx;
  logic [31:0] h_y;
  logic [5:0] h_tag;
  always #5 clk = ~clk;
  fround_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_inexact(out_inexact)
  );
  fround_pipe #(.EW(11), .MW(52), .TAGW(6)) dut_d (
    .clk(clk), .rstn(rstn), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_x(d_in_x),
    .in_mode(d_in_mode), .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_y(d_out_y), .out_tag(d_out_tag), .out_inexact(d_out_inexact)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask
  // value-level model: scale to an integer, round by remainder vs half, re-encode
  task automatic ref_round(input logic [31:0] x, input logic [1:0] md, output logic [31:0] y, output logic inx);
    logic s, up;
    int e, k, p;
    longint sig, qt, r, half, n;
    s = x[31];
    e = int'(x[30:23]);
    up = 1'b0;
    if (e == 255) begin
      y = (x[22:0] != 0) ? (x | 32'h0040_0000) : x;
      inx = 1'b0;
    end else if (e == 0) begin
      y = {s, 31'd0};
      inx = 1'b0;
    end else if (e >= 150) begin
      y = x;
      inx = 1'b0;
    end else begin
      sig = (64'd1 << 23) | longint'(x[22:0]);
      k = 150 - e;
      if (k > 40) k = 40;
      qt = sig >> k;
      r = sig - (qt << k);
      half = 64'd1 << (k - 1);
      inx = r != 0;
      case (md)
        2'd0: up = r > half || (r == half && qt[0]);
        2'd1: up = 1'b0;
        2'd2: up = s && r != 0;
        default: up = !s && r != 0;
      endcase
      n = qt + longint'(up);
      if (n == 0) y = {s, 31'd0};
      else begin
        p = 0;
        for (int i = 0; i < 40; i++) if (n[i]) p = i;
        y = {s, 8'(127 + p), 23'((n - (64'd1 << p)) << (23 - p))};
      end
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] x, input logic [1:0] md, input logic [5:0] tg,
                     input logic ordy, input logic dir, input logic [31:0] dy, input logic di, output logic acc);
    exp_t ent;
    logic [31:0] my;
    logic mi;
    @(negedge clk);
    in_valid = v; in_x = x; in_mode = md; in_tag = tg; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0 && now - q[0].cyc >= 2));
    if (stalled) begin
      chk("hold_y", 64'(out_y), 64'(h_y));
      chk("hold_tag", 64'(out_tag), 64'(h_tag));
      chk("hold_inexact", 64'(out_inexact), 64'(h_inx));
    end
    if (out_valid && ordy && q.size() > 0) begin
      ent = q.pop_front();
      chk("y", 64'(out_y), 64'(ent.y));
      chk("tag", 64'(out_tag), 64'(ent.tag));
      chk("inexact", 64'(out_inexact), 64'(ent.inx));
    end
    stalled = out_valid && !ordy;
    h_y = out_y; h_tag = out_tag; h_inx = out_inexact;
    acc = v && in_ready;
    if (acc) begin
      ref_round(x, md, my, mi);
      q.push_back('{dir ? dy : my, dir ? di : mi, tg, now});
    end
    now++;
  endtask
  task automatic go(input logic [31:0] x, input logic [1:0] md, input logic [5:0] tg, input logic [31:0] dy, input logic di);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cyc(1'b1, x, md, tg, 1'b1, 1'b1, dy, di, acc);
    chk("accepted", 64'(acc), 64'(1));
  endtask
  task automatic drain();
    logic acc;
    for (int i = 0; i < 12 && q.size() > 0; i++) cyc(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
    cyc(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
    chk("drained", 64'(q.size()), 64'(0));
  endtask
  initial begin
    logic acc;
    logic [31:0] ops [4];
    int sent, c;
    rstn = 1'b0;
    in_valid = 1'b0; in_x = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_x = '0; d_in_mode = '0; d_in_tag = '0; d_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_y", 64'(out_y), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    // mode sweep on 2.5
    go(32'h4020_0000, 2'd0, 6'd1, 32'h4000_0000, 1'b1);
    go(32'h4020_0000, 2'd2, 6'd2, 32'h4000_0000, 1'b1);
    go(32'h4020_0000, 2'd3, 6'd3, 32'h4040_0000, 1'b1);
    go(32'h4020_0000, 2'd1, 6'd4, 32'h4000_0000, 1'b1);
    drain();
    // carries into the exponent
    go(32'h3FC0_0000, 2'd3, 6'd5, 32'h4000_0000, 1'b1);
    go(32'hBF7F_FFFF, 2'd2, 6'd6, 32'hBF80_0000, 1'b1);
    go(32'hC020_0000, 2'd2, 6'd7, 32'hC040_0000, 1'b1);
    go(32'h3FC0_0000, 2'd0, 6'd8, 32'h4000_0000, 1'b1);
    drain();
    // specials
    go(32'h7F80_0001, 2'd0, 6'd9, 32'h7FC0_0001, 1'b0);
    go(32'hFF80_0000, 2'd2, 6'd10, 32'hFF80_0000, 1'b0);
    go(32'hBE99_999A, 2'd3, 6'd11, 32'h8000_0000, 1'b1);
    go(32'h0000_0001, 2'd3, 6'd12, 32'h0000_0000, 1'b0);
    go(32'h4B00_0001, 2'd0, 6'd13, 32'h4B00_0001, 1'b0);
    go(32'h8000_0000, 2'd3, 6'd14, 32'h8000_0000, 1'b0);
    drain();
    // backpressure: out_ready low on loop cycles 1..4
    ops[0] = 32'h4020_0000; ops[1] = 32'h4060_0000; ops[2] = 32'hBFC0_0000; ops[3] = 32'h3F33_3333;
    sent = 0; c = 0;
    while (sent < 4 && c < 20) begin
      cyc(1'b1, ops[sent], 2'd0, 6'(40 + sent), !(c >= 1 && c <= 4), 1'b0, '0, 1'b0, acc);
      if (acc) sent++;
      c++;
    end
    chk("bp_sent", 64'(sent), 64'(4));
    drain();
    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x;
      int sel;
      sel = $urandom_range(0, 19);
      x[31] = 1'($urandom_range(0, 1));
      x[30:23] = sel == 0 ? 8'd0 : sel == 1 ? 8'd255 : 8'($urandom_range(118, 152));
      x[22:0] = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
      cyc($urandom_range(0, 9) < 8, x, 2'($urandom_range(0, 3)), 6'($urandom), $urandom_range(0, 9) < 7, 1'b0, '0, 1'b0, acc);
    end
    drain();
    // reset with both stages full
    cyc(1'b1, 32'h4020_0000, 2'd3, 6'd50, 1'b0, 1'b0, '0, 1'b0, acc);
    cyc(1'b1, 32'h4060_0000, 2'd3, 6'd51, 1'b0, 1'b0, '0, 1'b0, acc);
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_y", 64'(out_y), 64'(0));
    chk("mid_rst_inexact", 64'(out_inexact), 64'(0));
    q.delete();
    stalled = 1'b0;
    repeat (3) cyc(1'b0, '0, 2'd0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
    go(32'hC020_0000, 2'd0, 6'd52, 32'hC000_0000, 1'b1);
    drain();
    // double-precision instance
    @(negedge clk);
    d_in_valid = 1'b1; d_in_x = 64'h4004_0000_0000_0000; d_in_mode = 2'd0; d_in_tag = 6'd21;
    @(negedge clk);
    d_in_x = 64'hC004_0000_0000_0000; d_in_mode = 2'd2; d_in_tag = 6'd22;
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    chk("dp_valid0", 64'(d_out_valid), 64'(1));
    chk("dp_y0", d_out_y, 64'h4000_0000_0000_0000);
    chk("dp_tag0", 64'(d_out_tag), 64'(21));
    chk("dp_inx0", 64'(d_out_inexact), 64'(1));
    @(negedge clk);
    #1;
    chk("dp_valid1", 64'(d_out_valid), 64'(1));
    chk("dp_y1", d_out_y, 64'hC008_0000_0000_0000);
    chk("dp_tag1", 64'(d_out_tag), 64'(22));
    @(negedge clk);
    #1;
    chk("dp_idle", 64'(d_out_valid), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
